// File: rtl/rect_motion_engine.sv
// rect_motion_engine: one on-screen rectangle stepped at a divided tick rate
// from direction switches, with a one-shot boost / 2x-scale on a button press
// and clamping at the screen edges. Also registers a per-pixel "inside" flag
// for the downstream colour mux.
// Optional build macro: RECT_WRAP_EN -- positions wrap around the screen
// instead of clamping at the edges.
module rect_motion_engine #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int COORD_W    = 11,
  parameter int BASE_W     = 100,
  parameter int BASE_H     = 50,
  parameter int INIT_X     = 269,
  parameter int INIT_Y     = 189,
  parameter int VEL        = 2,
  parameter int BOOST_DIST = 20,
  parameter int TICK_DIV   = 1250000
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic [3:0]         dir,
  input  logic               boost_n,
  input  logic               scale_mode,
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] row,
  input  logic               disp_ena,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [COORD_W-1:0] size_x,
  output logic [COORD_W-1:0] size_y,
  output logic [3:0]         at_edge,
  output logic               dir_err,
  output logic               pixel_on,
  output logic               tick
);

  // Size saturated to the screen dimension.
  function automatic int sat_dim(input int dim, input int scr);
    return (dim > scr) ? scr : dim;
  endfunction

  localparam int SW    = COORD_W + 2;
  localparam int EW    = COORD_W + 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [COORD_W-1:0] SZ_X_BASE = COORD_W'(sat_dim(BASE_W, SCREEN_W));
  localparam logic [COORD_W-1:0] SZ_Y_BASE = COORD_W'(sat_dim(BASE_H, SCREEN_H));
  localparam logic [COORD_W-1:0] SZ_X_BIG  = COORD_W'(sat_dim(2 * BASE_W, SCREEN_W));
  localparam logic [COORD_W-1:0] SZ_Y_BIG  = COORD_W'(sat_dim(2 * BASE_H, SCREEN_H));
  localparam logic signed [SW-1:0] SCR_X   = SW'(SCREEN_W);
  localparam logic signed [SW-1:0] SCR_Y   = SW'(SCREEN_H);
  localparam logic signed [SW-1:0] STEP_V  = SW'(VEL);
  localparam logic signed [SW-1:0] STEP_B  = SW'(BOOST_DIST);
  localparam logic [EW-1:0]        EDGE_X  = EW'(SCREEN_W);
  localparam logic [EW-1:0]        EDGE_Y  = EW'(SCREEN_H);

  // Clamp a signed coordinate into [0, hi].
  function automatic logic [COORD_W-1:0] clamp_axis(input logic signed [SW-1:0] v,
                                                    input logic signed [SW-1:0] hi);
    logic signed [SW-1:0] r;
    if (v < 0)       r = '0;
    else if (v > hi) r = hi;
    else             r = v;
    return COORD_W'(r);
  endfunction

  // Wrap a signed coordinate modulo (hi + 1); negatives land at the far edge.
  function automatic logic [COORD_W-1:0] wrap_axis(input logic signed [SW-1:0] v,
                                                   input logic signed [SW-1:0] hi);
    logic signed [SW-1:0] m;
    logic signed [SW-1:0] r;
    m = hi + SW'(1);
    r = v % m;
    if (r < 0) r = r + m;
    return COORD_W'(r);
  endfunction

  typedef enum logic {ARMED, SPENT} btn_state_t;

  logic [CNT_W-1:0]     r_cnt;
  logic [COORD_W-1:0]   r_pos_x, r_pos_y;
  logic                 r_big;
  logic                 r_dir_err;
  logic                 r_boost_prev;
  logic                 r_pixel_on;
  btn_state_t           r_state, w_state_nxt;

  logic                 w_tick, w_legal, w_press;
  logic [COORD_W-1:0]   w_size_x, w_size_y, w_size_x_nxt, w_size_y_nxt;
  logic signed [SW-1:0] w_step, w_dx, w_dy;
  logic signed [SW-1:0] w_max_x, w_max_y, w_max_x_nxt, w_max_y_nxt;
  logic [COORD_W-1:0]   w_new_x, w_new_y, w_rescl_x, w_rescl_y;
  logic [EW-1:0]        w_end_x, w_end_y;

  assign w_tick   = (r_cnt == CNT_LAST) && !reset;
  assign w_legal  = $onehot0(dir);
  assign w_size_x = r_big ? SZ_X_BIG : SZ_X_BASE;
  assign w_size_y = r_big ? SZ_Y_BIG : SZ_Y_BASE;
  assign w_size_x_nxt = r_big ? SZ_X_BASE : SZ_X_BIG;
  assign w_size_y_nxt = r_big ? SZ_Y_BASE : SZ_Y_BIG;
  assign w_end_x  = {1'b0, r_pos_x} + {1'b0, w_size_x};
  assign w_end_y  = {1'b0, r_pos_y} + {1'b0, w_size_y};

  // Free-running motion tick divider.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset)                  r_cnt <= '0;
    else if (r_cnt == CNT_LAST) r_cnt <= '0;
    else                        r_cnt <= r_cnt + CNT_W'(1);
  end

  // Button FSM state register.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) r_state <= ARMED;
    else       r_state <= w_state_nxt;
  end

  // Button FSM next state; a press edge in ARMED fires the one-shot action.
  always_comb begin
    w_state_nxt = r_state;
    w_press     = 1'b0;
    if (w_tick) begin
      case (r_state)
        ARMED: if (r_boost_prev && !boost_n) begin
          w_press     = 1'b1;
          w_state_nxt = SPENT;
        end
        SPENT: if (boost_n) w_state_nxt = ARMED;
        default: w_state_nxt = ARMED;
      endcase
    end
  end

  // Candidate step and edge-limited positions for this tick.
  always_comb begin
    w_step = (w_press && !scale_mode) ? STEP_B : STEP_V;
    w_dx   = '0;
    w_dy   = '0;
    if (dir[1])      w_dx = w_step;
    else if (dir[3]) w_dx = -w_step;
    if (dir[0])      w_dy = w_step;
    else if (dir[2]) w_dy = -w_step;
    w_max_x     = SCR_X - $signed({2'b00, w_size_x});
    w_max_y     = SCR_Y - $signed({2'b00, w_size_y});
    w_max_x_nxt = SCR_X - $signed({2'b00, w_size_x_nxt});
    w_max_y_nxt = SCR_Y - $signed({2'b00, w_size_y_nxt});
`ifdef RECT_WRAP_EN
    w_new_x = wrap_axis($signed({2'b00, r_pos_x}) + w_dx, w_max_x);
    w_new_y = wrap_axis($signed({2'b00, r_pos_y}) + w_dy, w_max_y);
`else
    w_new_x = clamp_axis($signed({2'b00, r_pos_x}) + w_dx, w_max_x);
    w_new_y = clamp_axis($signed({2'b00, r_pos_y}) + w_dy, w_max_y);
`endif
    w_rescl_x = clamp_axis($signed({2'b00, r_pos_x}), w_max_x_nxt);
    w_rescl_y = clamp_axis($signed({2'b00, r_pos_y}), w_max_y_nxt);
  end

  // Tick-rate state: position, size toggle, direction error, button history.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_pos_x      <= COORD_W'(INIT_X);
      r_pos_y      <= COORD_W'(INIT_Y);
      r_big        <= 1'b0;
      r_dir_err    <= 1'b0;
      r_boost_prev <= 1'b1;
    end else if (w_tick) begin
      r_dir_err    <= !w_legal;
      r_boost_prev <= boost_n;
      if (w_legal) begin
        if (w_press && scale_mode) begin
          r_big   <= ~r_big;
          r_pos_x <= w_rescl_x;
          r_pos_y <= w_rescl_y;
        end else begin
          r_pos_x <= w_new_x;
          r_pos_y <= w_new_y;
        end
      end
    end
  end

  // Registered inside-rectangle flag for the current pixel.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) r_pixel_on <= 1'b0;
    else       r_pixel_on <= disp_ena &&
                             ({1'b0, col} >= {1'b0, r_pos_x}) && ({1'b0, col} < w_end_x) &&
                             ({1'b0, row} >= {1'b0, r_pos_y}) && ({1'b0, row} < w_end_y);
  end

  assign pos_x    = r_pos_x;
  assign pos_y    = r_pos_y;
  assign size_x   = w_size_x;
  assign size_y   = w_size_y;
  assign dir_err  = r_dir_err;
  assign pixel_on = r_pixel_on;
  assign tick     = w_tick;
  assign at_edge  = {(r_pos_x == '0), (r_pos_y == '0),
                     (w_end_x == EDGE_X), (w_end_y == EDGE_Y)};

endmodule

// File: tb/tb_rect_motion_engine.sv
// Scoreboard bench for rect_motion_engine with a short tick divider.
module tb_rect_motion_engine;

  localparam int CW = 11;

  typedef struct {
    int       x;
    int       y;
    int       sx;
    int       sy;
    logic [3:0] edg;
    logic     err;
  } exp_t;

  logic          pixel_clk = 1'b0;
  logic          reset;
  logic [3:0]    dir;
  logic          boost_n;
  logic          scale_mode;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          disp_ena;
  logic [CW-1:0] pos_x, pos_y, size_x, size_y;
  logic [3:0]    at_edge;
  logic          dir_err, pixel_on, tick;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic pq[$];
  int   mx, my, msx, msy;

  rect_motion_engine #(.TICK_DIV(4)) dut (
    .pixel_clk(pixel_clk), .reset(reset), .dir(dir), .boost_n(boost_n),
    .scale_mode(scale_mode), .col(col), .row(row), .disp_ena(disp_ena),
    .pos_x(pos_x), .pos_y(pos_y), .size_x(size_x), .size_y(size_y),
    .at_edge(at_edge), .dir_err(dir_err), .pixel_on(pixel_on), .tick(tick)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] edge_of(input int x, input int y, input int sx, input int sy);
    return {x == 0, y == 0, x + sx == 640, y + sy == 480};
  endfunction

  // Queue the expected result of the next tick, hold inputs until it fires.
  task automatic run_tick(input logic [3:0] d, input logic bn, input logic sm,
                          input int ex, input int ey, input int esx, input int esy,
                          input logic [3:0] eedg, input logic eerr);
    exp_t e;
    int   n;
    dir = d; boost_n = bn; scale_mode = sm;
    e.x = ex; e.y = ey; e.sx = esx; e.sy = esy; e.edg = eedg; e.err = eerr;
    q.push_back(e);
    mx = ex; my = ey; msx = esx; msy = esy;
    n = 0;
    while (!tick && n < 20) begin
      @(negedge pixel_clk);
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL tick_wait actual=no_tick required=tick_within_20");
    end
    @(negedge pixel_clk);
  endtask

  // Plain VEL steps, expected positions from a clamping reference.
  task automatic move(input logic [3:0] d, input int n);
    int nx, ny;
    for (int i = 0; i < n; i++) begin
      nx = mx + (d[1] ? 2 : 0) - (d[3] ? 2 : 0);
      ny = my + (d[0] ? 2 : 0) - (d[2] ? 2 : 0);
      nx = (nx < 0) ? 0 : (nx > 640 - msx) ? 640 - msx : nx;
      ny = (ny < 0) ? 0 : (ny > 480 - msy) ? 480 - msy : ny;
      run_tick(d, 1'b1, 1'b0, nx, ny, msx, msy, edge_of(nx, ny, msx, msy), 1'b0);
    end
  endtask

  // Tick monitor: compare the registered state after each tick edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge pixel_clk);
      if (tick) begin
        @(posedge pixel_clk);
        #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          check("pos_x", int'(pos_x), e.x);
          check("pos_y", int'(pos_y), e.y);
          check("size_x", int'(size_x), e.sx);
          check("size_y", int'(size_y), e.sy);
          check("at_edge", int'(at_edge), int'(e.edg));
          check("dir_err", int'(dir_err), int'(e.err));
        end
      end
    end
  end

  // Pixel monitor: one cycle after each queued pixel vector.
  initial begin
    logic b;
    forever begin
      @(posedge pixel_clk);
      #1;
      if (pq.size() > 0) begin
        b = pq.pop_front();
        check("pixel_on", int'(pixel_on), int'(b));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic pix(input int c, input int r, input logic en, input logic req);
    col = CW'(c); row = CW'(r); disp_ena = en;
    pq.push_back(req);
    @(negedge pixel_clk);
  endtask

  initial begin
    int n;
    reset = 1'b1; dir = 4'b0000; boost_n = 1'b1; scale_mode = 1'b0;
    col = CW'(300); row = CW'(200); disp_ena = 1'b1;
    mx = 269; my = 189; msx = 100; msy = 50;
    repeat (3) @(negedge pixel_clk);
    check("rst_pos_x", int'(pos_x), 269);
    check("rst_pos_y", int'(pos_y), 189);
    check("rst_size_x", int'(size_x), 100);
    check("rst_size_y", int'(size_y), 50);
    check("rst_tick", int'(tick), 0);
    check("rst_dir_err", int'(dir_err), 0);
    check("rst_pixel_on", int'(pixel_on), 0);
    check("rst_at_edge", int'(at_edge), 0);

    // Three right steps; tick must appear only on every 4th cycle.
    dir = 4'b0010;
    for (int i = 1; i <= 3; i++) begin
      exp_t e;
      e.x = 269 + 2 * i; e.y = 189; e.sx = 100; e.sy = 50; e.edg = 4'b0000; e.err = 1'b0;
      q.push_back(e);
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge pixel_clk);
      check("tick_cycle", int'(tick), (k % 4 == 3) ? 1 : 0);
    end
    mx = 275;

    // Illegal direction: flagged, no move; legal idle clears it.
    run_tick(4'b0011, 1'b1, 1'b0, 275, 189, 100, 50, 4'b0000, 1'b1);
    run_tick(4'b0000, 1'b1, 1'b0, 275, 189, 100, 50, 4'b0000, 1'b0);

    // Walk to the right edge, back one step to 538.
    for (int i = 0; i < 200 && mx != 540; i++) move(4'b0010, 1);
    move(4'b1000, 1);
    // Boost clamps to the edge; held button gives VEL only; re-press boosts again.
    run_tick(4'b0010, 1'b0, 1'b0, 540, 189, 100, 50, 4'b0010, 1'b0);
    run_tick(4'b1000, 1'b0, 1'b0, 538, 189, 100, 50, 4'b0000, 1'b0);
    run_tick(4'b0010, 1'b0, 1'b0, 540, 189, 100, 50, 4'b0010, 1'b0);
    run_tick(4'b0000, 1'b1, 1'b0, 540, 189, 100, 50, 4'b0010, 1'b0);
    run_tick(4'b1000, 1'b0, 1'b0, 520, 189, 100, 50, 4'b0000, 1'b0);
    run_tick(4'b0000, 1'b1, 1'b0, 520, 189, 100, 50, 4'b0000, 1'b0);

    // Reset mid-window returns everything; first tick 4 cycles after release.
    boost_n = 1'b0;
    @(negedge pixel_clk);
    reset = 1'b1;
    @(negedge pixel_clk);
    check("rst2_pos_x", int'(pos_x), 269);
    check("rst2_tick", int'(tick), 0);
    dir = 4'b0000; boost_n = 1'b1; scale_mode = 1'b1;
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge pixel_clk);
      n++;
    end while (!tick && n < 10);
    check("first_tick_latency", n, 3);

    // Scale toggle at the reset position.
    run_tick(4'b0000, 1'b0, 1'b1, 269, 189, 200, 100, 4'b0000, 1'b0);
    run_tick(4'b0000, 1'b1, 1'b1, 269, 189, 200, 100, 4'b0000, 1'b0);
    run_tick(4'b0000, 1'b0, 1'b1, 269, 189, 100, 50, 4'b0000, 1'b0);
    run_tick(4'b0000, 1'b1, 1'b1, 269, 189, 100, 50, 4'b0000, 1'b0);

    // Move to (500,400), then grow: position pulled back to (440,380).
    for (int i = 0; i < 200 && mx != 540; i++) move(4'b0010, 1);
    move(4'b1000, 20);
    for (int i = 0; i < 200 && my != 430; i++) move(4'b0001, 1);
    move(4'b0100, 15);
    check("pre_scale_x", mx, 500);
    check("pre_scale_y", my, 400);
    run_tick(4'b0000, 1'b0, 1'b1, 440, 380, 200, 100, 4'b0011, 1'b0);
    run_tick(4'b0000, 1'b1, 1'b1, 440, 380, 200, 100, 4'b0011, 1'b0);

    // Pixel flag around the reset-position rectangle.
    reset = 1'b1;
    @(negedge pixel_clk);
    reset = 1'b0; scale_mode = 1'b0;
    pix(269, 189, 1'b1, 1'b1);
    pix(369, 189, 1'b1, 1'b0);
    pix(368, 238, 1'b1, 1'b1);
    pix(268, 189, 1'b1, 1'b0);
    pix(269, 239, 1'b1, 1'b0);
    pix(300, 200, 1'b0, 1'b0);
    repeat (3) @(negedge pixel_clk);

    if (q.size() != 0 || pq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain actual=%0d_pending required=0", q.size() + pq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
